// File: rtl/color_bounce_pkg.sv
// Shared geometry, colours and state encoding for the colour-bounce frame drawer.
// Screen is 160 columns wide; ball and platforms are fixed-size rectangles.
package color_bounce_pkg;

  localparam int SCREEN_W   = 160;
  localparam int BALL_SIZE  = 4;
  localparam int BALL_Y     = 58;
  localparam int PLAT_Y0    = 40;
  localparam int PLAT_PITCH = 10;
  localparam int PLAT_W     = 8;
  localparam int NUM_PLATS  = 4;

  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_BALL,
    ERASE_PLATS,
    DRAW_PLATS,
    DRAW_BALL,
    DONE
  } state_e;

  function automatic logic [6:0] plat_row(input logic [1:0] k);
    return 7'(PLAT_Y0 + PLAT_PITCH * int'(k));
  endfunction

endpackage

// File: rtl/frame_drawer_if.sv
// Request/pixel bundle between the game updater, the drawer and the VGA adapter.
// master issues draw requests; slave is the frame drawer.
interface frame_drawer_if;
  logic        start;
  logic [7:0]  prev_ball;
  logic [7:0]  curr_ball;
  logic [2:0]  color_ball;
  logic [31:0] position_plats;
  logic [11:0] color_plats;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output start, prev_ball, curr_ball, color_ball,
    output position_plats, color_plats,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, prev_ball, curr_ball, color_ball,
    input  position_plats, color_plats,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rect_scanner.sv
// Row-major dx/dy walker over a (w_max+1) x (h_max+1) rectangle.
// Wraps to 0,0 after the last cell, which doubles as the reload for the next shape.
module rect_scanner (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [2:0] w_max,
  input  logic [1:0] h_max,
  output logic [2:0] dx,
  output logic [1:0] dy,
  output logic       last
);

  logic [2:0] dx_q, dx_d;
  logic [1:0] dy_q, dy_d;

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == w_max) && (dy_q == h_max);

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clr) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en) begin
      if (dx_q == w_max) begin
        dx_d = '0;
        dy_d = last ? 2'd0 : dy_q + 2'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

endmodule

// File: rtl/frame_drawer.sv
// Per-frame pixel sequencer: erase old ball and platforms, draw new ones.
// Pixel outputs are registered one cycle behind the scan state.
module frame_drawer
  import color_bounce_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  frame_drawer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       curr_q, curr_d;
  logic [2:0]       cball_q, cball_d;
  logic [3:0][7:0]  pos_q, pos_d;
  logic [3:0][2:0]  pcol_q, pcol_d;
  logic [3:0][7:0]  old_q, old_d;
  logic             valid_q, valid_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [2:0]       colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       scan_clr, scan_en, scan_last;
  logic [2:0] w_max, dx;
  logic [1:0] h_max, dy;
  logic [7:0] base;
  logic [6:0] row;
  logic [2:0] pcol;
  logic       vis;
  logic [8:0] col9;

  rect_scanner u_scan (
    .clk   (clk),
    .rst   (reset),
    .clr   (scan_clr),
    .en    (scan_en),
    .w_max (w_max),
    .h_max (h_max),
    .dx    (dx),
    .dy    (dy),
    .last  (scan_last)
  );

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    curr_d   = curr_q;
    cball_d  = cball_q;
    pos_d    = pos_q;
    pcol_d   = pcol_q;
    old_d    = old_q;
    valid_d  = valid_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = BLACK;
    plot_d   = 1'b0;
    busy_d   = (state_q != IDLE);
    done_d   = (state_q == DONE);
    scan_clr = 1'b0;
    scan_en  = 1'b0;
    w_max    = 3'(BALL_SIZE - 1);
    h_max    = 2'(BALL_SIZE - 1);
    base     = '0;
    row      = '0;
    pcol     = BLACK;
    vis      = 1'b0;

    unique case (state_q)
      IDLE: begin
        scan_clr = 1'b1;
        if (bus.start) begin
          state_d = ERASE_BALL;
          prev_d  = bus.prev_ball;
          curr_d  = bus.curr_ball;
          cball_d = bus.color_ball;
          pos_d   = bus.position_plats;
          pcol_d  = bus.color_plats;
        end
      end
      ERASE_BALL: begin
        scan_en = 1'b1;
        base    = prev_q;
        row     = 7'(BALL_Y) + 7'(dy);
        vis     = 1'b1;
        if (scan_last) state_d = ERASE_PLATS;
      end
      ERASE_PLATS: begin
        scan_en = 1'b1;
        w_max   = 3'(PLAT_W - 1);
        h_max   = 2'(NUM_PLATS - 1);
        base    = old_q[dy];
        row     = plat_row(dy);
        vis     = valid_q;
        if (scan_last) state_d = DRAW_PLATS;
      end
      DRAW_PLATS: begin
        scan_en = 1'b1;
        w_max   = 3'(PLAT_W - 1);
        h_max   = 2'(NUM_PLATS - 1);
        base    = pos_q[dy];
        row     = plat_row(dy);
        pcol    = pcol_q[dy];
        vis     = 1'b1;
        if (scan_last) state_d = DRAW_BALL;
      end
      DRAW_BALL: begin
        scan_en = 1'b1;
        base    = curr_q;
        row     = 7'(BALL_Y) + 7'(dy);
        pcol    = cball_q;
        vis     = 1'b1;
        if (scan_last) begin
          state_d = DONE;
          old_d   = pos_q;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        scan_clr = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clip at the right edge rather than wrapping into column 0.
    col9 = {1'b0, base} + {6'b0, dx};
    if (scan_en) begin
      x_d = col9[7:0];
      y_d = row;
      if (vis && (col9 < 9'(SCREEN_W))) begin
        plot_d   = 1'b1;
        colour_d = pcol;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      curr_q   <= '0;
      cball_q  <= '0;
      pos_q    <= '0;
      pcol_q   <= '0;
      old_q    <= '0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      curr_q   <= curr_d;
      cball_q  <= cball_d;
      pos_q    <= pos_d;
      pcol_q   <= pcol_d;
      old_q    <= old_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
